// File: rtl/conv_rd_addr_gen.sv
// Read-side address sequencer for the convolution datapath.
// Sweeps the input feature map in sliding-window order and marks window and plane ends.
module conv_rd_addr_gen #(
    parameter int IN_R   = 32,
    parameter int IN_C   = 32,
    parameter int K      = 5,
    parameter int GROUPS = 1,
    parameter int OUT_CH = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              win_last,
    output logic              plane_last,
    output logic              busy,
    output logic              done
);

    localparam int OUT_R = IN_R - K + 1;
    localparam int OUT_C = IN_C - K + 1;
    localparam int PLANE = IN_R * IN_C;

    localparam int KW = (K > 1)      ? $clog2(K)      : 1;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CW = (OUT_C > 1)  ? $clog2(OUT_C)  : 1;
    localparam int RW = (OUT_R > 1)  ? $clog2(OUT_R)  : 1;
    localparam int HW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(GROUPS - 1);
    localparam logic [CW-1:0] OC_LAST = CW'(OUT_C - 1);
    localparam logic [RW-1:0] OR_LAST = RW'(OUT_R - 1);
    localparam logic [HW-1:0] CH_LAST = HW'(OUT_CH - 1);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IN_C);
    localparam logic [ADDR_W-1:0] GRP_STEP = ADDR_W'(PLANE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0] kx_q, kx_d;
    logic [KW-1:0] ky_q, ky_d;
    logic [GW-1:0] g_q, g_d;
    logic [CW-1:0] oc_q, oc_d;
    logic [RW-1:0] orow_q, orow_d;
    logic [HW-1:0] ch_q, ch_d;

    // Address is the sum of running offsets, so no per-beat multiplier is needed.
    logic [ADDR_W-1:0] ky_off_q, ky_off_d;
    logic [ADDR_W-1:0] grp_off_q, grp_off_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              win_last_q, win_last_d;
    logic              plane_last_q, plane_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic xfer;

    assign xfer = rd_valid_q && rd_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        g_d        = g_q;
        oc_d       = oc_q;
        orow_d     = orow_q;
        ch_d       = ch_q;
        ky_off_d   = ky_off_q;
        grp_off_d  = grp_off_q;
        row_base_d = row_base_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (kx_q != K_LAST) begin
                        kx_d = kx_q + 1'b1;
                    end else begin
                        kx_d = '0;
                        if (ky_q != K_LAST) begin
                            ky_d     = ky_q + 1'b1;
                            ky_off_d = ky_off_q + ROW_STEP;
                        end else begin
                            ky_d     = '0;
                            ky_off_d = '0;
                            if (g_q != G_LAST) begin
                                g_d       = g_q + 1'b1;
                                grp_off_d = grp_off_q + GRP_STEP;
                            end else begin
                                g_d       = '0;
                                grp_off_d = '0;
                                if (oc_q != OC_LAST) begin
                                    oc_d = oc_q + 1'b1;
                                end else begin
                                    oc_d = '0;
                                    if (orow_q != OR_LAST) begin
                                        orow_d     = orow_q + 1'b1;
                                        row_base_d = row_base_q + ROW_STEP;
                                    end else begin
                                        orow_d     = '0;
                                        row_base_d = '0;
                                        if (ch_q != CH_LAST) begin
                                            ch_d = ch_q + 1'b1;
                                        end else begin
                                            // Every counter has wrapped: the sweep is complete.
                                            ch_d    = '0;
                                            state_d = ST_DONE;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next-cycle state and counters.
        rd_valid_d   = (state_d == ST_RUN);
        busy_d       = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        rd_addr_d    = grp_off_d + row_base_d + ky_off_d + ADDR_W'(oc_d) + ADDR_W'(kx_d);
        win_last_d   = (state_d == ST_RUN) && (kx_d == K_LAST) && (ky_d == K_LAST)
                       && (g_d == G_LAST);
        plane_last_d = win_last_d && (oc_d == OC_LAST) && (orow_d == OR_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop is small, so all reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            kx_q         <= '0;
            ky_q         <= '0;
            g_q          <= '0;
            oc_q         <= '0;
            orow_q       <= '0;
            ch_q         <= '0;
            ky_off_q     <= '0;
            grp_off_q    <= '0;
            row_base_q   <= '0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            win_last_q   <= 1'b0;
            plane_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            g_q          <= g_d;
            oc_q         <= oc_d;
            orow_q       <= orow_d;
            ch_q         <= ch_d;
            ky_off_q     <= ky_off_d;
            grp_off_q    <= grp_off_d;
            row_base_q   <= row_base_d;
            rd_addr_q    <= rd_addr_d;
            rd_valid_q   <= rd_valid_d;
            win_last_q   <= win_last_d;
            plane_last_q <= plane_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign rd_valid   = rd_valid_q;
    assign win_last   = win_last_q;
    assign plane_last = plane_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
